// File: rtl/s7seg_pkg.sv
// s7seg_pkg - shared types and constants for the 7-segment display blocks.
//   SEG_W      : number of segment lines (a..g)
//   seg_t      : segment vector, bit 6 = a .. bit 0 = g, active-high
//   SEG_TABLE  : hex glyphs 0..F
//   SEG_BLANK  : all segments off (before any output polarity inversion)
package s7seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_TABLE [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/s7seg_decode.sv
// s7seg_decode - combinational hex to a..g segment decoder.
// Ports:
//   value : 4-bit digit to display
//   seg   : segment pattern, seg[6]=a .. seg[0]=g, active-high
// Kept standalone so the multi-digit mux driver can reuse it.
module s7seg_decode
  import s7seg_pkg::*;
(
  input  logic [3:0] value,
  output seg_t       seg
);

  assign seg = SEG_TABLE[value];

endmodule

// File: rtl/s7seg_tick_counter.sv
// s7seg_tick_counter - prescaled single-digit up/down counter driving a
// 7-segment display with a heartbeat decimal point.
// Parameters:
//   TICK_DIV       : clk cycles per tick (2..2^24)
//   MAX_DIGIT      : highest count value (1..15)
//   SEG_ACTIVE_LOW : 1 inverts seg and dp at the output register
// Ports:
//   clk, rst       : fabric clock, asynchronous active-high reset
//   en             : run prescaler (0 freezes prescaler, digit and dp)
//   up_dn          : 1 = count up, 0 = count down
//   load, load_val : synchronous load (clamped to MAX_DIGIT), beats a tick
//   bright         : PWM brightness, only with S7SEG_PWM_DIM_EN defined
//   digit, seg, dp : registered count, segments, heartbeat
//   tick, wrap     : one-cycle pulses when the digit advanced / wrapped
// Optional feature macro: S7SEG_PWM_DIM_EN (adds bright and a 4-bit PWM
// counter that blanks seg/dp when pwm_cnt >= bright).
module s7seg_tick_counter
  import s7seg_pkg::*;
#(
  parameter int TICK_DIV       = 4000000,
  parameter int MAX_DIGIT      = 9,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
`ifdef S7SEG_PWM_DIM_EN
  input  logic [3:0] bright,
`endif
  output logic [3:0] digit,
  output seg_t       seg,
  output logic       dp,
  output logic       tick,
  output logic       wrap
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]     MAX_D      = 4'(MAX_DIGIT);
  localparam logic           DP_POL     = (SEG_ACTIVE_LOW != 0);
  localparam seg_t           SEG_POL    = {SEG_W{DP_POL}};

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    digit_q, digit_d;
  logic          hb_q, hb_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          gate;
  seg_t          pattern;

  // Decode the next digit so seg lands on the same edge as digit.
  s7seg_decode u_decode (
    .value (digit_d),
    .seg   (pattern)
  );

`ifdef S7SEG_PWM_DIM_EN
  logic [3:0] pwm_q, pwm_d;

  // Gate on the count that will be current after this edge, so the
  // registered segments track pwm_q with no extra cycle of lag.
  always_comb begin
    pwm_d = pwm_q + 4'd1;
    gate  = (pwm_d < bright);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 4'd0;
    else     pwm_q <= pwm_d;
  end
`else
  always_comb gate = 1'b1;
`endif

  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    hb_d    = hb_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      digit_d = (load_val > MAX_D) ? MAX_D : load_val;
      presc_d = '0;
    end else if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        hb_d    = ~hb_q;
        tick_d  = 1'b1;
        if (up_dn) begin
          if (digit_q >= MAX_D) begin
            digit_d = 4'd0;
            wrap_d  = 1'b1;
          end else begin
            digit_d = digit_q + 4'd1;
          end
        end else if (digit_q == 4'd0) begin
          digit_d = MAX_D;
          wrap_d  = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    seg_d = (gate ? pattern : SEG_BLANK) ^ SEG_POL;
    dp_d  = (gate & hb_d) ^ DP_POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      digit_q <= 4'd0;
      hb_q    <= 1'b0;
      seg_q   <= SEG_TABLE[0] ^ SEG_POL;
      dp_q    <= DP_POL;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      hb_q    <= hb_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digit = digit_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_s7seg_tick_counter.sv
// Testbench for s7seg_tick_counter: two instances with different parameters
// share one randomized stimulus stream and are compared every cycle against
// a modular-arithmetic reference model.
module tb_s7seg_tick_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, load;
  logic [3:0] load_val;
`ifdef S7SEG_PWM_DIM_EN
  logic [3:0] bright;
`endif

  logic [3:0] digit0, digit1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, tick0, tick1, wrap0, wrap1;

  always #5 clk = ~clk;

  s7seg_tick_counter #(.TICK_DIV(4), .MAX_DIGIT(9), .SEG_ACTIVE_LOW(0)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
`ifdef S7SEG_PWM_DIM_EN
    .bright   (bright),
`endif
    .digit    (digit0),
    .seg      (seg0),
    .dp       (dp0),
    .tick     (tick0),
    .wrap     (wrap0)
  );

  s7seg_tick_counter #(.TICK_DIV(3), .MAX_DIGIT(15), .SEG_ACTIVE_LOW(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
`ifdef S7SEG_PWM_DIM_EN
    .bright   (bright),
`endif
    .digit    (digit1),
    .seg      (seg1),
    .dp       (dp1),
    .tick     (tick1),
    .wrap     (wrap1)
  );

  // Segment glyphs abcdefg, written out independently of the design package.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int p_div [2] = '{4, 3};
  int p_max [2] = '{9, 15};
  bit p_al  [2] = '{1'b0, 1'b1};

  int m_cnt [2];
  int m_dig [2];
  bit m_hb  [2];
  bit m_tick[2];
  bit m_wrap[2];
  int m_pwm;
  bit m_gate;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_dig[i] = 0; m_hb[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
    end
    m_pwm  = 0;
    m_gate = 1'b1;
  endtask

  // Advance the model by one clock edge given the inputs in force at that edge.
  task automatic model_edge(input bit e, input bit u, input bit ld, input int lv, input int br);
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 0;
      m_wrap[i] = 0;
      if (ld) begin
        m_dig[i] = (lv > p_max[i]) ? p_max[i] : lv;
        m_cnt[i] = 0;
      end else if (e) begin
        if (m_cnt[i] == p_div[i] - 1) begin
          m_cnt[i]  = 0;
          m_hb[i]   = ~m_hb[i];
          m_tick[i] = 1;
          if (u) begin
            m_wrap[i] = (m_dig[i] == p_max[i]);
            m_dig[i]  = (m_dig[i] + 1) % (p_max[i] + 1);
          end else begin
            m_wrap[i] = (m_dig[i] == 0);
            m_dig[i]  = (m_dig[i] + p_max[i]) % (p_max[i] + 1);
          end
        end else begin
          m_cnt[i]++;
        end
      end
    end
`ifdef S7SEG_PWM_DIM_EN
    m_pwm  = (m_pwm + 1) % 16;
    m_gate = (m_pwm < br);
`else
    m_gate = (br >= 0);
`endif
  endtask

  function automatic logic [6:0] exp_seg(input int i);
    logic [6:0] s;
    s = m_gate ? glyph[m_dig[i]] : 7'b0000000;
    return p_al[i] ? ~s : s;
  endfunction

  function automatic logic exp_dp(input int i);
    return (m_gate & m_hb[i]) ^ p_al[i];
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".digit0"}, {4'd0, digit0}, 8'(m_dig[0]));
    chk({ph, ".seg0"},   {1'b0, seg0},   {1'b0, exp_seg(0)});
    chk({ph, ".dp0"},    {7'd0, dp0},    {7'd0, exp_dp(0)});
    chk({ph, ".tick0"},  {7'd0, tick0},  {7'd0, m_tick[0]});
    chk({ph, ".wrap0"},  {7'd0, wrap0},  {7'd0, m_wrap[0]});
    chk({ph, ".digit1"}, {4'd0, digit1}, 8'(m_dig[1]));
    chk({ph, ".seg1"},   {1'b0, seg1},   {1'b0, exp_seg(1)});
    chk({ph, ".dp1"},    {7'd0, dp1},    {7'd0, exp_dp(1)});
    chk({ph, ".tick1"},  {7'd0, tick1},  {7'd0, m_tick[1]});
    chk({ph, ".wrap1"},  {7'd0, wrap1},  {7'd0, m_wrap[1]});
  endtask

  // Entered and left at a falling edge. Optionally asserts reset in the
  // middle of the high phase after the rising edge has been checked.
  task automatic step(input string ph, input bit e, input bit u, input bit ld,
                      input int lv, input int br, input bit do_rst);
    en       = e;
    up_dn    = u;
    load     = ld;
    load_val = 4'(lv);
`ifdef S7SEG_PWM_DIM_EN
    bright   = 4'(br);
`endif
    model_edge(e, u, ld, lv, br);
    @(posedge clk);
    #1;
    check_all(ph);
    if (do_rst) begin
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  int br_cur;
  int bound;
  bit found;
  bit up_r;

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
`ifdef S7SEG_PWM_DIM_EN
    bright = 4'd15;
`endif
    br_cur = 15;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Free-running count up through several wraps.
    for (int k = 0; k < 44; k++) step("up", 1, 1, 0, 0, br_cur, 0);

    // Count down through the 0 -> MAX_DIGIT wrap.
    for (int k = 0; k < 24; k++) step("down", 1, 0, 0, 0, br_cur, 0);

    // Over-range load clamps.
    step("load12", 1, 1, 1, 12, br_cur, 0);
    step("post_load", 1, 1, 0, 0, br_cur, 0);

    // Load on the tick cycle of instance 0 must suppress tick and wrap.
    found = 0;
    for (bound = 0; bound < 10 && !found; bound++) begin
      if (m_cnt[0] == p_div[0] - 1) found = 1;
      else step("seek_tick", 1, 1, 0, 0, br_cur, 0);
    end
    chk("seek_tick_found", {7'd0, found}, 8'd1);
    step("load_on_tick", 1, 1, 1, 3, br_cur, 0);

    // Freeze mid-period, then resume: the next tick comes at the remainder.
    for (int k = 0; k < 6; k++) step("pre_freeze", 1, 1, 0, 0, br_cur, 0);
    for (int k = 0; k < 10; k++) step("freeze", 0, 1, 0, 0, br_cur, 0);
    for (int k = 0; k < 8; k++) step("resume", 1, 1, 0, 0, br_cur, 0);
    for (int k = 0; k < 3; k++) step("load_frozen", 0, 1, 1, k + 7, br_cur, 0);

    // Async reset mid-prescale with digit 5.
    step("ld4", 1, 1, 1, 4, br_cur, 0);
    found = 0;
    for (bound = 0; bound < 200 && !found; bound++) begin
      if (m_dig[0] == 5 && m_cnt[0] != 0) found = 1;
      step("seek5", 1, 1, 0, 0, br_cur, found);
    end
    chk("seek5_found", {7'd0, found}, 8'd1);

    // Randomized traffic.
    up_r = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) up_r = ~up_r;
`ifdef S7SEG_PWM_DIM_EN
      if ($urandom_range(0, 63) == 0) br_cur = $urandom_range(0, 15);
`endif
      step("rand", $urandom_range(0, 7) != 0, up_r, $urandom_range(0, 19) == 0,
           $urandom_range(0, 15), br_cur, $urandom_range(0, 299) == 0);
    end

`ifdef S7SEG_PWM_DIM_EN
    for (int k = 0; k < 32; k++) step("pwm4", 1, 1, 0, 0, 4, 0);
    for (int k = 0; k < 32; k++) step("pwm0", 1, 1, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
